// File: rtl/mcmem_pkg.sv
// Shared types and widths for the multicycle memory responder.
package mcmem_pkg;

  typedef enum logic [1:0] {IDLE, WAIT, RESP} mcmem_state_t;

  localparam int WORD_W = 32;
  localparam int CNT_W  = 4;

endpackage

// File: rtl/mcmem_array.sv
// Single-port synchronous word RAM with a registered read port; contents are not reset.
module mcmem_array
  import mcmem_pkg::*;
#(
  parameter int DEPTH = 64,
  parameter int IDX_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              we,
  input  logic [IDX_W-1:0]  idx,
  input  logic [WORD_W-1:0] wd,
  output logic [WORD_W-1:0] rd
);

  logic [WORD_W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[idx] <= wd;
    end
    rd <= mem[idx];
  end

endmodule

// File: rtl/mcmem_responder.sv
// Wait-state memory responder for the multicycle MIPS datapath.
// Optional misaligned-address check enabled by MCMEM_ALIGN_CHECK_EN (adds port err).
//
// state | meaning
// IDLE  | waiting for req; request is captured on acceptance
// WAIT  | counting down wait states; access happens when cnt reaches 0
// RESP  | one-cycle ready pulse, then back to IDLE
module mcmem_responder
  import mcmem_pkg::*;
#(
  parameter int DEPTH   = 64,
  parameter int LATENCY = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req,
  input  logic              we,
  input  logic [31:0]       addr,
  input  logic [WORD_W-1:0] wdata,
  output logic [WORD_W-1:0] rdata,
  output logic              ready,
  output logic              busy
`ifdef MCMEM_ALIGN_CHECK_EN
  ,
  output logic              err
`endif
);

  localparam int IDX_W = $clog2(DEPTH);

  mcmem_state_t      state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              we_q, we_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic [WORD_W-1:0] wdata_q, wdata_d;
  logic [WORD_W-1:0] rdata_q, rdata_d;
  logic              mis_q, mis_d;

  logic              accept;
  logic              access;
  logic              misalign;
  logic              mem_we;
  logic [IDX_W-1:0]  mem_idx;
  logic [WORD_W-1:0] mem_rd;
  logic              unused_addr;

`ifdef MCMEM_ALIGN_CHECK_EN
  assign misalign    = (addr[1:0] != 2'b00);
  assign err         = (state_q == RESP) && mis_q;
  assign unused_addr = ^addr[31:2+IDX_W];
`else
  assign misalign    = 1'b0;
  assign unused_addr = ^{addr[31:2+IDX_W], addr[1:0]};
`endif

  assign accept = (state_q == IDLE) && req;
  assign access = (state_q == WAIT) && (cnt_q == '0);
  assign mem_we = access && we_q && !mis_q;

  // Present the incoming index while IDLE so the registered read port already
  // holds the word by the time the last wait state ends, even for LATENCY=1.
  assign mem_idx = (state_q == IDLE) ? addr[2 +: IDX_W] : idx_q;

  mcmem_array #(
    .DEPTH (DEPTH),
    .IDX_W (IDX_W)
  ) u_array (
    .clk (clk),
    .we  (mem_we),
    .idx (mem_idx),
    .wd  (wdata_q),
    .rd  (mem_rd)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (req) state_d = WAIT;
      WAIT:    if (cnt_q == '0) state_d = RESP;
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    ready = 1'b0;
    busy  = 1'b0;
    case (state_q)
      WAIT:    busy = 1'b1;
      RESP: begin
        ready = 1'b1;
        busy  = 1'b1;
      end
      default: ;
    endcase
  end

  always_comb begin
    cnt_d   = cnt_q;
    we_d    = we_q;
    idx_d   = idx_q;
    wdata_d = wdata_q;
    mis_d   = mis_q;
    rdata_d = rdata_q;
    if (accept) begin
      cnt_d   = CNT_W'(LATENCY - 1);
      we_d    = we;
      idx_d   = addr[2 +: IDX_W];
      wdata_d = wdata;
      mis_d   = misalign;
    end else if ((state_q == WAIT) && (cnt_q != '0)) begin
      cnt_d = cnt_q - 1'b1;
    end
    if (access && !we_q && !mis_q) begin
      rdata_d = mem_rd;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q   <= '0;
      we_q    <= 1'b0;
      idx_q   <= '0;
      wdata_q <= '0;
      mis_q   <= 1'b0;
      rdata_q <= '0;
    end else begin
      cnt_q   <= cnt_d;
      we_q    <= we_d;
      idx_q   <= idx_d;
      wdata_q <= wdata_d;
      mis_q   <= mis_d;
      rdata_q <= rdata_d;
    end
  end

  assign rdata = rdata_q;

endmodule

// File: tb/tb_mcmem_responder.sv
// Directed bench for mcmem_responder at DEPTH=64, LATENCY=2.
module tb_mcmem_responder;

  logic        clk = 1'b0;
  logic        reset;
  logic        req;
  logic        we;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic        ready;
  logic        busy;
`ifdef MCMEM_ALIGN_CHECK_EN
  logic        err;
`endif

  int checks   = 0;
  int failures = 0;

  mcmem_responder #(.DEPTH(64), .LATENCY(2)) dut (
    .clk   (clk),
    .reset (reset),
    .req   (req),
    .we    (we),
    .addr  (addr),
    .wdata (wdata),
    .rdata (rdata),
    .ready (ready),
    .busy  (busy)
`ifdef MCMEM_ALIGN_CHECK_EN
    ,
    .err   (err)
`endif
  );

  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic cur_err();
`ifdef MCMEM_ALIGN_CHECK_EN
    return err;
`else
    return 1'b0;
`endif
  endfunction

  // Runs one transaction from an IDLE cycle; returns rdata/err seen with ready.
  task automatic xact(input logic w, input logic [31:0] a, input logic [31:0] d,
                      output logic [31:0] rd_at, output logic err_at);
    int lat;
    req = 1'b1; we = w; addr = a; wdata = d;
    tick();
    req = 1'b0; we = 1'b0; addr = 32'h0; wdata = 32'h0;
    lat = 1;
    while (!ready && lat < 10) begin
      tick();
      lat++;
    end
    check_val("latency", 32'(lat), 32'd3);
    rd_at  = rdata;
    err_at = cur_err();
    tick();
  endtask

  initial begin
    logic [31:0] r;
    logic        e;
    int          nrdy;

    reset = 1'b1; req = 1'b1; we = 1'b0; addr = 32'h0; wdata = 32'h0;
    tick(); tick();
    check_val("rst_ready", {31'h0, ready}, 32'h0);
    check_val("rst_busy", {31'h0, busy}, 32'h0);
    check_val("rst_rdata", rdata, 32'h0);
    reset = 1'b0; req = 1'b0;
    nrdy = 0;
    for (int i = 0; i < 4; i++) begin
      tick();
      if (ready || busy) nrdy++;
    end
    check_val("idle_no_xact", 32'(nrdy), 32'd0);

    xact(1'b1, 32'h08, 32'hDEADBEEF, r, e);
    check_val("wr_rdata_kept", r, 32'h0);
    xact(1'b0, 32'h08, 32'h0, r, e);
    check_val("rd_after_wr", r, 32'hDEADBEEF);
    tick(); tick();
    check_val("rdata_held", rdata, 32'hDEADBEEF);

    xact(1'b1, 32'h100, 32'h12345678, r, e);
    check_val("wr_resp_rdata", r, 32'hDEADBEEF);
    xact(1'b0, 32'h000, 32'h0, r, e);
    check_val("wrap_alias", r, 32'h12345678);

    xact(1'b1, 32'h04, 32'h11111111, r, e);
    req = 1'b1; we = 1'b0; addr = 32'h04; wdata = 32'h0;
    tick();
    nrdy = 0;
    for (int c = 1; c <= 3; c++) begin
      req = 1'b1; we = 1'b1; addr = 32'h04; wdata = 32'hFFFFFFFF;
      check_val($sformatf("busy_c%0d", c), {31'h0, busy}, 32'h1);
      if (ready) nrdy++;
      tick();
    end
    req = 1'b0; we = 1'b0; addr = 32'h0; wdata = 32'h0;
    for (int c = 4; c < 9; c++) begin
      if (ready) nrdy++;
      tick();
    end
    check_val("busy_one_ready", 32'(nrdy), 32'd1);
    check_val("busy_rdata", rdata, 32'h11111111);
    xact(1'b0, 32'h04, 32'h0, r, e);
    check_val("busy_word_kept", r, 32'h11111111);

    xact(1'b1, 32'h0C, 32'h5A5A0001, r, e);
    req = 1'b1; we = 1'b1; addr = 32'h0C; wdata = 32'hA5A5A5A5;
    tick();
    reset = 1'b1; req = 1'b0; we = 1'b0; addr = 32'h0; wdata = 32'h0;
    tick();
    reset = 1'b0;
    check_val("midwait_rdata_rst", rdata, 32'h0);
    nrdy = 0;
    for (int i = 0; i < 5; i++) begin
      if (ready || busy) nrdy++;
      tick();
    end
    check_val("midwait_no_ready", 32'(nrdy), 32'd0);
    xact(1'b0, 32'h0C, 32'h0, r, e);
    check_val("midwait_no_write", r, 32'h5A5A0001);

`ifdef MCMEM_ALIGN_CHECK_EN
    xact(1'b1, 32'h0D, 32'h1, r, e);
    check_val("mis_err", {31'h0, e}, 32'h1);
    check_val("mis_rdata", r, 32'h5A5A0001);
    xact(1'b0, 32'h0C, 32'h0, r, e);
    check_val("mis_no_write", r, 32'h5A5A0001);
    check_val("aligned_err", {31'h0, e}, 32'h0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
